// File: rtl/decode_pkg.sv
// decode_pkg: shared opcodes, ALU modes, FSM states and the decode bundle type
//   Bundle field widths come from XLEN_P/RW_P; decode_unit and decode_logic
//   default their XLEN/RW parameters to these values and expect them to match.
package decode_pkg;
   localparam int XLEN_P = 32;
   localparam int RW_P   = 4;
   localparam logic [5:0] OP_ALU_LO = 6'b000010;
   localparam logic [5:0] OP_ALU_HI = 6'b010111;
   localparam logic [5:0] OP_MEM_LO = 6'b011010;
   localparam logic [5:0] OP_MEM_HI = 6'b011111;
   localparam logic [5:0] OP_BEQ    = 6'b100000;
   localparam logic [5:0] OP_BNE    = 6'b100001;
   localparam logic [5:0] OP_J      = 6'b100010;
   localparam logic [5:0] OP_JR     = 6'b100011;
   localparam logic [5:0] OP_JAL    = 6'b100100;
   localparam logic [5:0] OP_MFHI   = 6'b100101;
   localparam logic [3:0] ALU_ADD   = 4'b0001;
   localparam logic [3:0] ALU_MFHI  = 4'b1101;
   localparam logic [3:0] ALU_EQ    = 4'b1110;
   localparam logic [3:0] ALU_NEQ   = 4'b1111;
   typedef enum logic [1:0] {RUN, HALTED, TRAP} state_t;
   typedef struct packed {
      logic [RW_P-1:0]   r1;
      logic [RW_P-1:0]   r2;
      logic [RW_P-1:0]   w1;
      logic [XLEN_P-1:0] imm;
      logic [3:0]        alu_mode;
      logic              imm_flag;
      logic              reg_write;
      logic              mem_write;
      logic              mem_read;
      logic              pc_read;
      logic              is_jump;
      logic              is_branch;
      logic [XLEN_P-1:0] mask;
   } dec_bundle_t;
endpackage

// File: rtl/decode_logic.sv
// decode_logic: purely combinational instruction word -> decode bundle
//   instr   in   XLEN   instruction word
//   bundle  out  dec_bundle_t  decoded fields (all zero for illegal opcodes)
//   illegal out  1      opcode is not in the instruction set
module decode_logic
   import decode_pkg::*;
#(
   parameter int XLEN     = XLEN_P,
   parameter int RW       = RW_P,
   parameter int JW       = 12,
   parameter int SIGN_IMM = 0
) (
   input  logic [XLEN-1:0] instr,
   output dec_bundle_t     bundle,
   output logic            illegal
);
   localparam int IMM_W = XLEN - 6 - 2 * RW;
   logic [5:0]      op;
   logic [RW-1:0]   d, s, t;
   logic [XLEN-1:0] zimm, simm, timm, ext;
   assign op   = instr[XLEN-1 -: 6];
   assign d    = instr[XLEN-7 -: RW];
   assign s    = instr[XLEN-7-RW -: RW];
   assign t    = instr[XLEN-7-2*RW -: RW];
   assign zimm = {{(XLEN-IMM_W){1'b0}}, instr[IMM_W-1:0]};
   assign simm = {{(XLEN-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
   assign timm = {{(XLEN-JW){1'b0}}, instr[XLEN-7 -: JW]};
   // branch offsets are always signed; only arith/mem immediates follow SIGN_IMM
   assign ext  = (SIGN_IMM != 0) ? simm : zimm;
   always_comb begin
      bundle  = '0;
      illegal = 1'b0;
      if (op inside {[OP_ALU_LO:OP_ALU_HI]}) begin
         bundle.alu_mode  = op[4:1];
         bundle.imm_flag  = op[0];
         bundle.w1        = d;
         bundle.r1        = s;
         bundle.r2        = op[0] ? '0 : t;
         bundle.imm       = op[0] ? ext : '0;
         bundle.mask      = '1;
         bundle.reg_write = 1'b1;
      end else if (op inside {[OP_MEM_LO:OP_MEM_HI]}) begin
         bundle.alu_mode  = ALU_ADD;
         bundle.w1        = d;
         bundle.r1        = s;
         bundle.r2        = d;
         bundle.imm       = ext;
         bundle.imm_flag  = 1'b1;
         // op[2:1] selects byte / half / word lanes
         bundle.mask      = (op[2:1] == 2'b01) ? {{(XLEN-8){1'b0}}, 8'hFF} :
                            (op[2:1] == 2'b10) ? {{(XLEN-16){1'b0}}, 16'hFFFF} : '1;
         bundle.reg_write = ~op[0];
         bundle.mem_read  = ~op[0];
         bundle.mem_write = op[0];
      end else if (op == OP_BEQ || op == OP_BNE) begin
         bundle.alu_mode  = op[0] ? ALU_NEQ : ALU_EQ;
         bundle.r1        = d;
         bundle.r2        = s;
         bundle.imm       = simm;
         bundle.is_branch = 1'b1;
      end else if (op == OP_J || op == OP_JAL) begin
         bundle.alu_mode  = ALU_ADD;
         bundle.imm       = timm;
         bundle.imm_flag  = 1'b1;
         bundle.is_jump   = 1'b1;
         if (op == OP_JAL) begin
            bundle.w1        = '1;
            bundle.reg_write = 1'b1;
            bundle.pc_read   = 1'b1;
            bundle.mask      = '1;
         end
      end else if (op == OP_JR) begin
         bundle.alu_mode  = ALU_ADD;
         bundle.r2        = d;
         bundle.is_jump   = 1'b1;
      end else if (op == OP_MFHI) begin
         bundle.alu_mode  = ALU_MFHI;
         bundle.w1        = d;
         bundle.reg_write = 1'b1;
         bundle.mask      = '1;
      end else begin
         illegal = 1'b1;
      end
   end
endmodule

// File: rtl/decode_unit.sv
// decode_unit: handshaked instruction decoder with registered bundle, halt FSM and counter
//   clk, rst_n (async active-low)
//   in_valid/in_ready/in_instr      fetch side handshake
//   out_valid/out_ready             execute side handshake
//   r1, r2, w1, imm, alu_mode, imm_flag, reg_write, mem_write, mem_read,
//   pc_read, is_jump, is_branch, mask   registered decode bundle
//   is_halted                       decoder stopped by an illegal opcode
//   dec_count                       bundles consumed by execute (wraps)
//   trap_valid/trap_instr/trap_ack  recoverable trap instead of halt, built only
//                                   when DECODE_TRAP_EN is defined
module decode_unit
   import decode_pkg::*;
#(
   parameter int XLEN     = XLEN_P,
   parameter int RW       = RW_P,
   parameter int JW       = 12,
   parameter int SIGN_IMM = 0,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RW-1:0]    r1,
   output logic [RW-1:0]    r2,
   output logic [RW-1:0]    w1,
   output logic [XLEN-1:0]  imm,
   output logic [3:0]       alu_mode,
   output logic             imm_flag,
   output logic             reg_write,
   output logic             mem_write,
   output logic             mem_read,
   output logic             pc_read,
   output logic             is_jump,
   output logic             is_branch,
   output logic [XLEN-1:0]  mask,
   output logic             is_halted,
`ifdef DECODE_TRAP_EN
   output logic             trap_valid,
   output logic [XLEN-1:0]  trap_instr,
   input  logic             trap_ack,
`endif
   output logic [CNT_W-1:0] dec_count
);
`ifdef DECODE_TRAP_EN
   localparam state_t ILL_STATE = TRAP;
`else
   localparam state_t ILL_STATE = HALTED;
`endif
   state_t           state_q, state_d;
   dec_bundle_t      bundle_q, bundle_d, dec;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] dec_count_q, dec_count_d;
   logic             illegal, fire, consume;
`ifdef DECODE_TRAP_EN
   logic [XLEN-1:0]  trap_instr_q, trap_instr_d;
`endif
   decode_logic #(.XLEN(XLEN), .RW(RW), .JW(JW), .SIGN_IMM(SIGN_IMM)) u_logic (
      .instr   (in_instr),
      .bundle  (dec),
      .illegal (illegal)
   );
   assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
   assign fire     = in_valid && in_ready;
   assign consume  = out_valid_q && out_ready;
   always_comb begin
      // an illegal fire loads nothing; a bundle draining the same cycle still leaves
      out_valid_d = (fire && !illegal) ? 1'b1 : consume ? 1'b0 : out_valid_q;
      bundle_d    = (fire && !illegal) ? dec : bundle_q;
      dec_count_d = dec_count_q + CNT_W'(consume);
      state_d     = (state_q == RUN && fire && illegal) ? ILL_STATE : state_q;
`ifdef DECODE_TRAP_EN
      state_d      = (state_q == TRAP && trap_ack) ? RUN : state_d;
      trap_instr_d = (fire && illegal) ? in_instr : trap_instr_q;
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         bundle_q     <= '0;
         out_valid_q  <= 1'b0;
         dec_count_q  <= '0;
`ifdef DECODE_TRAP_EN
         trap_instr_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         bundle_q     <= bundle_d;
         out_valid_q  <= out_valid_d;
         dec_count_q  <= dec_count_d;
`ifdef DECODE_TRAP_EN
         trap_instr_q <= trap_instr_d;
`endif
      end
   end
   assign out_valid = out_valid_q;
   assign r1        = bundle_q.r1;
   assign r2        = bundle_q.r2;
   assign w1        = bundle_q.w1;
   assign imm       = bundle_q.imm;
   assign alu_mode  = bundle_q.alu_mode;
   assign imm_flag  = bundle_q.imm_flag;
   assign reg_write = bundle_q.reg_write;
   assign mem_write = bundle_q.mem_write;
   assign mem_read  = bundle_q.mem_read;
   assign pc_read   = bundle_q.pc_read;
   assign is_jump   = bundle_q.is_jump;
   assign is_branch = bundle_q.is_branch;
   assign mask      = bundle_q.mask;
   assign is_halted = (state_q == HALTED);
   assign dec_count = dec_count_q;
`ifdef DECODE_TRAP_EN
   assign trap_valid = (state_q == TRAP);
   assign trap_instr = trap_instr_q;
`endif
endmodule

// File: tb/tb_decode_unit.sv
// tb_decode_unit: table-driven scoreboard bench for decode_unit (zero- and sign-extending instances)
module tb_decode_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        trap_ack = 1'b0;
   logic [31:0] in_instr = '0;
   logic        in_ready, out_valid, imm_flag, reg_write, mem_write, mem_read, pc_read, is_jump, is_branch, is_halted;
   logic [3:0]  r1, r2, w1, alu_mode;
   logic [31:0] imm, mask;
   logic [15:0] dec_count;
   logic        s_in_ready, s_out_valid, s_imm_flag, s_reg_write, s_mem_write, s_mem_read, s_pc_read, s_is_jump, s_is_branch, s_is_halted;
   logic [3:0]  s_r1, s_r2, s_w1, s_alu_mode;
   logic [31:0] s_imm, s_mask;
   logic [15:0] s_dec_count;
`ifdef DECODE_TRAP_EN
   logic        trap_valid, s_trap_valid;
   logic [31:0] trap_instr, s_trap_instr;
`endif
   typedef struct {
      logic [31:0] instr;
      logic [3:0]  alu, w1, r1, r2;
      logic [31:0] imm, imm_s, mask;
      logic [6:0]  ctrl;
   } vec_t;
   vec_t tbl[13];
   vec_t sb[$];
   vec_t mon_e;
   vec_t bad;
   int   n_cmp = 0, n_bad = 0, stalls = 0;
   bit   sb_en = 1'b1;
   logic [5:0] ill_ops[6];
   always #5 clk = ~clk;
   decode_unit #(.SIGN_IMM(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .r1(r1), .r2(r2), .w1(w1), .imm(imm),
      .alu_mode(alu_mode), .imm_flag(imm_flag), .reg_write(reg_write), .mem_write(mem_write),
      .mem_read(mem_read), .pc_read(pc_read), .is_jump(is_jump), .is_branch(is_branch),
      .mask(mask), .is_halted(is_halted),
`ifdef DECODE_TRAP_EN
      .trap_valid(trap_valid), .trap_instr(trap_instr), .trap_ack(trap_ack),
`endif
      .dec_count(dec_count)
   );
   decode_unit #(.SIGN_IMM(1)) u_sext (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr),
      .out_valid(s_out_valid), .out_ready(out_ready), .r1(s_r1), .r2(s_r2), .w1(s_w1), .imm(s_imm),
      .alu_mode(s_alu_mode), .imm_flag(s_imm_flag), .reg_write(s_reg_write), .mem_write(s_mem_write),
      .mem_read(s_mem_read), .pc_read(s_pc_read), .is_jump(s_is_jump), .is_branch(s_is_branch),
      .mask(s_mask), .is_halted(s_is_halted),
`ifdef DECODE_TRAP_EN
      .trap_valid(s_trap_valid), .trap_instr(s_trap_instr), .trap_ack(trap_ack),
`endif
      .dec_count(s_dec_count)
   );
   function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] d, input logic [3:0] s, input logic [17:0] lo);
      return {op, d, s, lo};
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   // scoreboard: each consumed bundle is compared against the oldest pushed expectation
   always @(negedge clk) begin
      if (rst_n && sb_en && out_valid && out_ready) begin
         if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
         else begin
            mon_e = sb.pop_front();
            chk("alu_mode", {28'd0, alu_mode}, {28'd0, mon_e.alu});
            chk("w1", {28'd0, w1}, {28'd0, mon_e.w1});
            chk("r1", {28'd0, r1}, {28'd0, mon_e.r1});
            chk("r2", {28'd0, r2}, {28'd0, mon_e.r2});
            chk("imm", imm, mon_e.imm);
            chk("imm_sext", s_imm, mon_e.imm_s);
            chk("mask", mask, mon_e.mask);
            chk("ctrl", {25'd0, imm_flag, reg_write, mem_write, mem_read, pc_read, is_jump, is_branch}, {25'd0, mon_e.ctrl});
         end
      end
   end
   task automatic send(input vec_t v, input bit push);
      int k = 0;
      in_valid = 1'b1;
      in_instr = v.instr;
      @(negedge clk);
      while (!in_ready && k < 50) begin
         k++;
         stalls++;
         @(negedge clk);
      end
      if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
      if (push) sb.push_back(v);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask
   task automatic drain();
      int k = 0;
      out_ready = 1'b1;
      while (out_valid && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("drain", {31'd0, out_valid}, 32'd0);
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_is_halted", {31'd0, is_halted}, 32'd0);
      chk("rst_dec_count", {16'd0, dec_count}, 32'd0);
      chk("rst_imm", imm, 32'd0);
      chk("rst_mask", mask, 32'd0);
      chk("rst_fields", {16'd0, w1, r1, r2, alu_mode}, 32'd0);
      chk("rst_ctrl", {25'd0, imm_flag, reg_write, mem_write, mem_read, pc_read, is_jump, is_branch}, 32'd0);
      chk("sb_empty", sb.size(), 32'd0);
      sb.delete();
      in_valid = 1'b0;
      out_ready = 1'b0;
      trap_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask
   initial begin
      tbl[0]  = '{instr: mk(6'b000010, 4'd2, 4'd5, {4'd2, 14'h0}), alu: 4'b0001, w1: 4'd2, r1: 4'd5, r2: 4'd2,
                  imm: 32'h0, imm_s: 32'h0, mask: 32'hFFFF_FFFF, ctrl: 7'b0100000};
      tbl[1]  = '{instr: mk(6'b000011, 4'd1, 4'd3, 18'h3FFFF), alu: 4'b0001, w1: 4'd1, r1: 4'd3, r2: 4'd0,
                  imm: 32'h0003_FFFF, imm_s: 32'hFFFF_FFFF, mask: 32'hFFFF_FFFF, ctrl: 7'b1100000};
      tbl[2]  = '{instr: mk(6'b010110, 4'd7, 4'd8, {4'd9, 14'h2ABC}), alu: 4'b1011, w1: 4'd7, r1: 4'd8, r2: 4'd9,
                  imm: 32'h0, imm_s: 32'h0, mask: 32'hFFFF_FFFF, ctrl: 7'b0100000};
      tbl[3]  = '{instr: mk(6'b010111, 4'd15, 4'd0, 18'h1FFFF), alu: 4'b1011, w1: 4'd15, r1: 4'd0, r2: 4'd0,
                  imm: 32'h0001_FFFF, imm_s: 32'h0001_FFFF, mask: 32'hFFFF_FFFF, ctrl: 7'b1100000};
      tbl[4]  = '{instr: mk(6'b011010, 4'd3, 4'd4, 18'h20010), alu: 4'b0001, w1: 4'd3, r1: 4'd4, r2: 4'd3,
                  imm: 32'h0002_0010, imm_s: 32'hFFFE_0010, mask: 32'h0000_00FF, ctrl: 7'b1101000};
      tbl[5]  = '{instr: mk(6'b011101, 4'd5, 4'd6, 18'h00004), alu: 4'b0001, w1: 4'd5, r1: 4'd6, r2: 4'd5,
                  imm: 32'h4, imm_s: 32'h4, mask: 32'h0000_FFFF, ctrl: 7'b1010000};
      tbl[6]  = '{instr: mk(6'b011110, 4'd8, 4'd9, 18'h00100), alu: 4'b0001, w1: 4'd8, r1: 4'd9, r2: 4'd8,
                  imm: 32'h100, imm_s: 32'h100, mask: 32'hFFFF_FFFF, ctrl: 7'b1101000};
      tbl[7]  = '{instr: mk(6'b100000, 4'd1, 4'd2, 18'h3FFFE), alu: 4'b1110, w1: 4'd0, r1: 4'd1, r2: 4'd2,
                  imm: 32'hFFFF_FFFE, imm_s: 32'hFFFF_FFFE, mask: 32'h0, ctrl: 7'b0000001};
      tbl[8]  = '{instr: mk(6'b100001, 4'd3, 4'd4, 18'h00010), alu: 4'b1111, w1: 4'd0, r1: 4'd3, r2: 4'd4,
                  imm: 32'h10, imm_s: 32'h10, mask: 32'h0, ctrl: 7'b0000001};
      tbl[9]  = '{instr: mk(6'b100010, 4'hA, 4'hB, {4'hC, 14'h0}), alu: 4'b0001, w1: 4'd0, r1: 4'd0, r2: 4'd0,
                  imm: 32'hABC, imm_s: 32'hABC, mask: 32'h0, ctrl: 7'b1000010};
      tbl[10] = '{instr: mk(6'b100100, 4'hF, 4'hF, {4'hF, 14'h1234}), alu: 4'b0001, w1: 4'hF, r1: 4'd0, r2: 4'd0,
                  imm: 32'hFFF, imm_s: 32'hFFF, mask: 32'hFFFF_FFFF, ctrl: 7'b1100110};
      tbl[11] = '{instr: mk(6'b100011, 4'd6, 4'd7, 18'h0), alu: 4'b0001, w1: 4'd0, r1: 4'd0, r2: 4'd6,
                  imm: 32'h0, imm_s: 32'h0, mask: 32'h0, ctrl: 7'b0000010};
      tbl[12] = '{instr: mk(6'b100101, 4'hC, 4'd1, 18'h0), alu: 4'b1101, w1: 4'hC, r1: 4'd0, r2: 4'd0,
                  imm: 32'h0, imm_s: 32'h0, mask: 32'hFFFF_FFFF, ctrl: 7'b0100000};
      ill_ops = '{6'b000000, 6'b000001, 6'b011000, 6'b011001, 6'b100110, 6'b111111};
      bad = tbl[0];
      do_reset();
      // every legal opcode class streamed back to back
      out_ready = 1'b1;
      for (int i = 0; i < 13; i++) send(tbl[i], 1'b1);
      drain();
      chk("count_table", {16'd0, dec_count}, 32'd13);
      // stall behind a valid bundle, then release
      do_reset();
      chk("pre_fire_valid", {31'd0, out_valid}, 32'd0);
      send(tbl[0], 1'b1);
      chk("latency_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b1;
      in_instr = tbl[1].instr;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_w1_r1", {24'd0, w1, r1}, 32'h25);
         chk("stall_alu", {28'd0, alu_mode}, 32'd1);
         @(posedge clk);
         #1;
      end
      chk("stall_count", {16'd0, dec_count}, 32'd0);
      out_ready = 1'b1;
      send(tbl[1], 1'b1);
      chk("release_count", {16'd0, dec_count}, 32'd1);
      chk("release_valid", {31'd0, out_valid}, 32'd1);
      drain();
      chk("release_count2", {16'd0, dec_count}, 32'd2);
      // LB, SH, LW at one per cycle
      do_reset();
      out_ready = 1'b1;
      stalls = 0;
      send(tbl[4], 1'b1);
      send(tbl[5], 1'b1);
      send(tbl[6], 1'b1);
      chk("stream_stalls", stalls, 32'd0);
      drain();
      chk("stream_count", {16'd0, dec_count}, 32'd3);
      // illegal opcode queued behind a pending bundle
      do_reset();
      send(tbl[0], 1'b1);
      in_valid = 1'b1;
      in_instr = 32'h0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("ill_wait_ready", {31'd0, in_ready}, 32'd0);
         chk("ill_wait_halt", {31'd0, is_halted}, 32'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("ill_out_valid", {31'd0, out_valid}, 32'd0);
      chk("ill_drain_count", {16'd0, dec_count}, 32'd1);
      chk("ill_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef DECODE_TRAP_EN
      chk("trap_valid", {31'd0, trap_valid}, 32'd1);
      chk("trap_instr", trap_instr, 32'h0);
      chk("trap_not_halted", {31'd0, is_halted}, 32'd0);
`else
      chk("halted", {31'd0, is_halted}, 32'd1);
`endif
      in_instr = tbl[0].instr;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("blocked_ready", {31'd0, in_ready}, 32'd0);
         chk("blocked_valid", {31'd0, out_valid}, 32'd0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
`ifdef DECODE_TRAP_EN
      trap_ack = 1'b1;
      @(posedge clk);
      #1;
      trap_ack = 1'b0;
      chk("trap_cleared", {31'd0, trap_valid}, 32'd0);
      chk("trap_ready", {31'd0, in_ready}, 32'd1);
      send(tbl[12], 1'b1);
      drain();
`else
      chk("halted_sticky", {31'd0, is_halted}, 32'd1);
`endif
      // every illegal opcode class from idle
      for (int i = 0; i < 6; i++) begin
         do_reset();
         out_ready = 1'b1;
         bad.instr = {ill_ops[i], 26'h155_5555};
         send(bad, 1'b0);
         chk("ill_op_valid", {31'd0, out_valid}, 32'd0);
`ifdef DECODE_TRAP_EN
         chk("ill_op_trap", {31'd0, trap_valid}, 32'd1);
         chk("ill_op_tinstr", trap_instr, bad.instr);
`else
         chk("ill_op_halt", {31'd0, is_halted}, 32'd1);
         chk("ill_op_ready", {31'd0, in_ready}, 32'd0);
`endif
      end
      // counter wrap and reset mid-stall
      do_reset();
      sb_en = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_instr = tbl[0].instr;
      repeat (65535) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      drain();
      chk("count_ffff", {16'd0, dec_count}, 32'h0000_FFFF);
      out_ready = 1'b0;
      send(tbl[0], 1'b0);
      chk("wrap_pending", {31'd0, out_valid}, 32'd1);
      chk("wrap_before", {16'd0, dec_count}, 32'h0000_FFFF);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("wrap_zero", {16'd0, dec_count}, 32'd0);
      send(tbl[0], 1'b0);
      drain();
      chk("wrap_one", {16'd0, dec_count}, 32'd1);
      out_ready = 1'b0;
      send(tbl[2], 1'b0);
      chk("midstall_valid", {31'd0, out_valid}, 32'd1);
      do_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
